// File: rtl/axis_pipe_pkg.sv
// rtl/axis_pipe_pkg.sv - shared constants and stage-0 adder for axis_skid_pipe
// AXIS_SKID_PIPE_SAT_EN selects a saturating stage-0 add instead of wrap-around.
package axis_pipe_pkg;

  localparam int MAX_STAGES = 16;
  localparam int MAX_DWIDTH = 63;

  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

  // The sum is formed one bit wider than width so the carry out is visible.
  function automatic logic [63:0] add_incr(input logic [63:0] data,
                                           input logic [63:0] incr,
                                           input int          width);
    logic [63:0] mask;
    logic [63:0] sum;
    mask = (64'd1 << width) - 64'd1;
    sum  = (data & mask) + (incr & mask);
`ifdef AXIS_SKID_PIPE_SAT_EN
    if ((sum & ~mask) != 64'd0) begin
      sum = mask;
    end
`endif
    return sum & mask;
  endfunction

endpackage

// File: rtl/axis_skid_stage.sv
// rtl/axis_skid_stage.sv - one full-throughput skid-buffer stage
// Upstream ready is a flop that always equals the inverse of the skid-valid flag.
module axis_skid_stage #(
  parameter int DWIDTH = 8
) (
  input  logic              aclk_i,
  input  logic              areset_i,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occ
);

  logic              m_v;
  logic              s_v;
  logic [DWIDTH-1:0] m_d;
  logic [DWIDTH-1:0] s_d;
  logic              rdy_q;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & ~s_v;
  assign out_xfer = m_v & out_ready;

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      m_v   <= 1'b0;
      s_v   <= 1'b0;
      m_d   <= '0;
      s_d   <= '0;
      rdy_q <= 1'b1;
    end else if (out_xfer && s_v) begin
      // Skid drains into main; upstream was held off this cycle.
      m_d   <= s_d;
      s_v   <= 1'b0;
      rdy_q <= 1'b1;
    end else if (in_xfer && (!m_v || out_ready)) begin
      m_d <= in_data;
      m_v <= 1'b1;
    end else if (in_xfer && m_v && !out_ready) begin
      s_d   <= in_data;
      s_v   <= 1'b1;
      rdy_q <= 1'b0;
    end else if (out_xfer && !in_xfer && !s_v) begin
      m_v <= 1'b0;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = m_v;
  assign out_data  = m_d;
  assign occ       = 2'(m_v) + 2'(s_v);

endmodule

// File: rtl/axis_skid_pipe.sv
// rtl/axis_skid_pipe.sv - chain of STAGES skid stages adding INCR to every beat
// AXIS_SKID_PIPE_SAT_EN (see axis_pipe_pkg) makes the stage-0 add saturate.
module axis_skid_pipe
  import axis_pipe_pkg::*;
#(
  parameter int          DWIDTH = 8,
  parameter int          STAGES = 2,
  parameter int unsigned INCR   = 1
) (
  input  logic                           aclk_i,
  input  logic                           areset_i,
  input  logic                           valid_i,
  input  logic [DWIDTH-1:0]              data_i,
  output logic                           ready_o,
  output logic                           valid_o,
  output logic [DWIDTH-1:0]              data_o,
  input  logic                           ready_i,
  output logic [occ_width(STAGES)-1:0]   occupancy_o
);

  localparam int OCC_W = occ_width(STAGES);

  // Element k is the boundary feeding stage k; element STAGES is the pipe output.
  logic              chain_valid [STAGES+1];
  logic              chain_ready [STAGES+1];
  logic [DWIDTH-1:0] chain_data  [STAGES+1];
  logic [1:0]        stage_occ   [STAGES];
  logic [OCC_W-1:0]  occ_sum;

  assign chain_valid[0]  = valid_i;
  assign chain_data[0]   = DWIDTH'(add_incr(64'(data_i), 64'(INCR), DWIDTH));
  assign ready_o         = chain_ready[0];
  assign chain_ready[STAGES] = ready_i;
  assign valid_o         = chain_valid[STAGES];
  assign data_o          = chain_data[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    axis_skid_stage #(
      .DWIDTH(DWIDTH)
    ) u_stage (
      .aclk_i   (aclk_i),
      .areset_i (areset_i),
      .in_valid (chain_valid[k]),
      .in_data  (chain_data[k]),
      .in_ready (chain_ready[k]),
      .out_valid(chain_valid[k+1]),
      .out_data (chain_data[k+1]),
      .out_ready(chain_ready[k+1]),
      .occ      (stage_occ[k])
    );
  end

  // Sum of flop bits only, so it tracks the flags and clears with the async reset.
  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_sum = occ_sum + OCC_W'(stage_occ[k]);
    end
  end

  assign occupancy_o = occ_sum;

endmodule

// File: tb/tb_axis_skid_pipe.sv
// tb/tb_axis_skid_pipe.sv - directed and scoreboarded checks of axis_skid_pipe
// Expected values follow AXIS_SKID_PIPE_SAT_EN when it is defined.
module tb_axis_skid_pipe;

  logic        aclk_i = 1'b0;
  logic        areset_i;
  always #5 aclk_i = ~aclk_i;

  logic        a_valid_i, a_ready_i, a_ready_o, a_valid_o;
  logic [7:0]  a_data_i, a_data_o;
  logic [2:0]  a_occ;

  logic        b_valid_i, b_ready_i, b_ready_o, b_valid_o;
  logic [15:0] b_data_i, b_data_o;
  logic [1:0]  b_occ;

  int n_cmp = 0;
  int n_err = 0;

  axis_skid_pipe #(.DWIDTH(8), .STAGES(2), .INCR(1)) u_dut_a (
    .aclk_i(aclk_i), .areset_i(areset_i),
    .valid_i(a_valid_i), .data_i(a_data_i), .ready_o(a_ready_o),
    .valid_o(a_valid_o), .data_o(a_data_o), .ready_i(a_ready_i),
    .occupancy_o(a_occ)
  );

  axis_skid_pipe #(.DWIDTH(16), .STAGES(1), .INCR(32'h0100)) u_dut_b (
    .aclk_i(aclk_i), .areset_i(areset_i),
    .valid_i(b_valid_i), .data_i(b_data_i), .ready_o(b_ready_o),
    .valid_o(b_valid_o), .data_o(b_data_o), .ready_i(b_ready_i),
    .occupancy_o(b_occ)
  );

  task automatic tick();
    @(posedge aclk_i);
    #1;
  endtask

  function automatic logic [7:0] exp_a(input logic [7:0] d);
    logic [8:0] s;
    s = {1'b0, d} + 9'd1;
`ifdef AXIS_SKID_PIPE_SAT_EN
    if (s[8]) return 8'hFF;
`endif
    return s[7:0];
  endfunction

  function automatic logic [15:0] exp_b(input logic [15:0] d);
    logic [16:0] s;
    s = {1'b0, d} + 17'h00100;
`ifdef AXIS_SKID_PIPE_SAT_EN
    if (s[16]) return 16'hFFFF;
`endif
    return s[15:0];
  endfunction

  task automatic test_reset();
    areset_i  = 1'b1;
    a_valid_i = 1'b0; a_data_i = 8'h00; a_ready_i = 1'b0;
    b_valid_i = 1'b0; b_data_i = 16'h0; b_ready_i = 1'b0;
    tick(); tick();
    areset_i = 1'b0;
    tick();
    n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_a_valid got %b want 0", a_valid_o); end
    n_cmp++; if (a_data_o !== 8'h00) begin n_err++; $display("FAIL reset_a_data got %h want 00", a_data_o); end
    n_cmp++; if (a_occ !== 3'd0) begin n_err++; $display("FAIL reset_a_occ got %0d want 0", a_occ); end
    n_cmp++; if (a_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_a_ready got %b want 1", a_ready_o); end
    n_cmp++; if (b_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_b_valid got %b want 0", b_valid_o); end
    n_cmp++; if (b_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_b_ready got %b want 1", b_ready_o); end
  endtask

  task automatic test_stream();
    a_ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      a_valid_i = (c < 10);
      a_data_i  = 8'(c);
      tick();
      if (c >= 1 && c <= 10) begin
        n_cmp++; if (a_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid c=%0d got %b want 1", c, a_valid_o); end
        n_cmp++; if (a_data_o !== 8'(c)) begin n_err++; $display("FAIL stream_data c=%0d got %h want %h", c, a_data_o, 8'(c)); end
      end else begin
        n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_idle c=%0d got %b want 0", c, a_valid_o); end
      end
      if (c >= 1 && c <= 9) begin
        n_cmp++; if (a_occ !== 3'd2) begin n_err++; $display("FAIL stream_occ c=%0d got %0d want 2", c, a_occ); end
      end
    end
    a_valid_i = 1'b0;
  endtask

  task automatic test_wrap();
    a_ready_i = 1'b1;
    a_valid_i = 1'b1; a_data_i = 8'hFF;
    tick();
    a_valid_i = 1'b0;
    tick();
    n_cmp++; if (a_valid_o !== 1'b1) begin n_err++; $display("FAIL wrap_valid got %b want 1", a_valid_o); end
`ifdef AXIS_SKID_PIPE_SAT_EN
    n_cmp++; if (a_data_o !== 8'hFF) begin n_err++; $display("FAIL wrap_data got %h want ff", a_data_o); end
`else
    n_cmp++; if (a_data_o !== 8'h00) begin n_err++; $display("FAIL wrap_data got %h want 00", a_data_o); end
`endif
    tick();
  endtask

  task automatic test_back_pressure();
    int acc;
    int got;
    logic xfer;
    acc = 0;
    a_ready_i = 1'b0;
    a_valid_i = 1'b1; a_data_i = 8'h10;
    for (int c = 0; c < 8; c++) begin
      xfer = a_ready_o;
      tick();
      if (xfer) begin acc++; a_data_i = a_data_i + 8'd1; end
    end
    a_valid_i = 1'b0;
    n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL bp_accepted got %0d want 4", acc); end
    n_cmp++; if (a_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", a_ready_o); end
    n_cmp++; if (a_occ !== 3'd4) begin n_err++; $display("FAIL bp_occ got %0d want 4", a_occ); end
    n_cmp++; if (a_data_o !== 8'h11) begin n_err++; $display("FAIL bp_head got %h want 11", a_data_o); end
    got = 0;
    a_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (a_valid_o) begin
        n_cmp++; if (a_data_o !== 8'(8'h11 + got)) begin n_err++; $display("FAIL bp_order idx=%0d got %h want %h", got, a_data_o, 8'(8'h11 + got)); end
        got++;
      end
      tick();
    end
    n_cmp++; if (got !== 4) begin n_err++; $display("FAIL bp_drained got %0d want 4", got); end
    n_cmp++; if (a_occ !== 3'd0) begin n_err++; $display("FAIL bp_empty_occ got %0d want 0", a_occ); end
  endtask

  task automatic test_random();
    logic [7:0] sb[$];
    logic [7:0] want;
    logic       in_x, out_x, stall;
    logic [7:0] hold_d;
    int n_in, n_out, cyc;
    n_in = 0; n_out = 0; cyc = 0;
    while (n_out < 10000 && cyc < 60000) begin
      a_valid_i = (n_in < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      a_data_i  = 8'($urandom);
      a_ready_i = 1'($urandom_range(0, 1));
      in_x  = a_valid_i & a_ready_o;
      out_x = a_valid_o & a_ready_i;
      stall = a_valid_o & ~a_ready_i;
      hold_d = a_data_o;
      if (out_x) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rand_extra beat got %h want none", a_data_o);
        end else begin
          want = sb.pop_front();
          if (a_data_o !== want) begin n_err++; $display("FAIL rand_data beat=%0d got %h want %h", n_out, a_data_o, want); end
        end
        n_out++;
      end
      if (in_x) begin sb.push_back(exp_a(a_data_i)); n_in++; end
      tick();
      cyc++;
      if (stall) begin
        n_cmp++; if (a_valid_o !== 1'b1 || a_data_o !== hold_d) begin n_err++; $display("FAIL rand_stall cyc=%0d got %b/%h want 1/%h", cyc, a_valid_o, a_data_o, hold_d); end
      end
      n_cmp++; if (a_occ !== 3'(sb.size())) begin n_err++; $display("FAIL rand_occ cyc=%0d got %0d want %0d", cyc, a_occ, sb.size()); end
    end
    n_cmp++; if (n_out !== 10000) begin n_err++; $display("FAIL rand_budget got %0d beats want 10000", n_out); end
    a_valid_i = 1'b0;
    a_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    a_ready_i = 1'b0;
    a_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      a_data_i = 8'(8'h30 + c);
      tick();
    end
    a_valid_i = 1'b0;
    n_cmp++; if (a_occ !== 3'd3) begin n_err++; $display("FAIL areset_pre_occ got %0d want 3", a_occ); end
    #2;
    areset_i = 1'b1;
    #1;
    n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL areset_valid got %b want 0", a_valid_o); end
    n_cmp++; if (a_occ !== 3'd0) begin n_err++; $display("FAIL areset_occ got %0d want 0", a_occ); end
    n_cmp++; if (a_ready_o !== 1'b1) begin n_err++; $display("FAIL areset_ready got %b want 1", a_ready_o); end
    n_cmp++; if (a_data_o !== 8'h00) begin n_err++; $display("FAIL areset_data got %h want 00", a_data_o); end
    tick();
    areset_i = 1'b0;
    a_ready_i = 1'b1;
    a_valid_i = 1'b1; a_data_i = 8'h20;
    tick();
    a_valid_i = 1'b0;
    tick();
    n_cmp++; if (a_valid_o !== 1'b1 || a_data_o !== 8'h21) begin n_err++; $display("FAIL areset_first got %b/%h want 1/21", a_valid_o, a_data_o); end
    tick();
  endtask

  task automatic test_stages1();
    logic [15:0] sb[$];
    logic [15:0] want;
    logic        in_x, out_x;
    b_ready_i = 1'b1;
    b_valid_i = 1'b1; b_data_i = 16'hFF00;
    tick();
    b_valid_i = 1'b0;
    n_cmp++; if (b_valid_o !== 1'b1) begin n_err++; $display("FAIL s1_latency got %b want 1", b_valid_o); end
    n_cmp++; if (b_data_o !== exp_b(16'hFF00)) begin n_err++; $display("FAIL s1_wrap got %h want %h", b_data_o, exp_b(16'hFF00)); end
    tick();
    for (int c = 0; c < 24; c++) begin
      if (c == 3) begin
        n_cmp++; if (b_occ !== 2'd2) begin n_err++; $display("FAIL s1_max_occ got %0d want 2", b_occ); end
        n_cmp++; if (b_ready_o !== 1'b0) begin n_err++; $display("FAIL s1_full_ready got %b want 0", b_ready_o); end
      end
      b_ready_i = (c >= 3) && c[0];
      b_valid_i = (c < 14);
      b_data_i  = 16'(c);
      in_x  = b_valid_i & b_ready_o;
      out_x = b_valid_o & b_ready_i;
      if (out_x) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL s1_extra got %h want none", b_data_o);
        end else begin
          want = sb.pop_front();
          if (b_data_o !== want) begin n_err++; $display("FAIL s1_data got %h want %h", b_data_o, want); end
        end
      end
      if (in_x) sb.push_back(exp_b(b_data_i));
      tick();
      n_cmp++; if (b_occ !== 2'(sb.size())) begin n_err++; $display("FAIL s1_occ c=%0d got %0d want %0d", c, b_occ, sb.size()); end
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL s1_drain got %0d left want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_back_pressure();
    test_random();
    test_async_reset();
    test_stages1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_skid_pipe.md
Name: axis_skid_pipe

Overview:
- Parametrised successor of the single-register ready/valid increment stage: a chain of STAGES full-throughput skid-buffer stages.
- Adds constant INCR to each beat, modulo 2^DWIDTH.
- Honours downstream back-pressure: no beat is lost or duplicated, and ready_o is registered.
- Sits between any two AXI-Stream-style ready/valid endpoints in the datapath.

Parameters:
- DWIDTH, 8: data width in bits (>=1).
- STAGES, 2: number of chained skid stages, i.e. latency in cycles (1..16).
- INCR, 1: constant added to each beat in stage 0; truncated to DWIDTH bits.

Ports:
- aclk_i, input, 1: clock; all logic on the rising edge.
- areset_i, input, 1: reset, asynchronous, active-high.
- valid_i, input, 1: upstream beat valid.
- data_i, input, DWIDTH: upstream beat data.
- ready_o, output, 1: upstream may transfer; driven directly from a flop.
- valid_o, output, 1: downstream beat valid.
- data_o, output, DWIDTH: downstream beat data.
- ready_i, input, 1: downstream accepts.
- occupancy_o, output, $clog2(2*STAGES+1): number of beats held in the pipe.

Behaviour:
- Reset (asynchronous assert, released on a clock edge): every main_v/skid_v = 0, every data register = 0. Outputs: valid_o=0, data_o=0, occupancy_o=0, ready_o=1.
- Stage k contents: main register (m_v, m_d) and skid register (s_v, s_d).
- Stage k output valid = m_v, output data = m_d; input ready = ~s_v (registered).
- Stage k input is stage k-1 output; stage 0 input is valid_i/data_i+INCR; stage STAGES-1 drives valid_o/data_o.
- Transfer at a stage boundary = valid & ready in the same cycle.
- Per stage, each cycle: in_xfer = in_v & ~s_v; out_xfer = m_v & out_ready.
  - out_xfer & s_v: main <= skid, s_v <= 0. in_xfer is impossible in this case since ready is low.
  - in_xfer & (~m_v | out_ready): main <= in, m_v <= 1.
  - in_xfer & m_v & ~out_ready: skid <= in, s_v <= 1.
  - out_xfer, no in_xfer, ~s_v: m_v <= 0.
  - Otherwise hold.
- Latency: STAGES cycles from valid_i&ready_o to valid_o with ready_i held high.
- Throughput: 1 beat/cycle sustained.
- ready_i low for N cycles: the pipe absorbs up to 2*STAGES beats, then ready_o drops.
- ready_o rises the cycle after the first downstream transfer frees stage 0's skid (propagation is one stage per cycle).
- Ordering is strictly FIFO.
- valid_o, once high, stays high with data_o stable until ready_i is sampled high.
- data_o must not depend combinationally on ready_i or valid_i.
- Arithmetic: data_i + INCR computed in DWIDTH+1 bits; the lower DWIDTH bits are kept (wrap-around, e.g. 8'hFF+1 -> 8'h00).
- occupancy_o: registered sum of all m_v and s_v bits.
  - Range 0..2*STAGES.
  - Updates the same cycle as the flags.
  - Simultaneous in/out transfer leaves it unchanged.
- Reset mid-stream: all in-flight beats are discarded immediately and asynchronously; outputs return to reset values without a clock.

Optional Feature:
- AXIS_SKID_PIPE_SAT_EN defined: stage-0 add saturates; if the DWIDTH+1 sum overflows, the result is all-ones (8'hFE+2 -> 8'hFF).
- Undefined: wrap-around as above (8'hFE+2 -> 8'h00).
- No port changes either way.

Decomposition:
- Package axis_pipe_pkg:
  - function occ_width(stages) returning $clog2(2*stages+1);
  - localparam MAX_STAGES=16;
  - add function add_incr(data, incr) containing the wrap/saturate selection under the macro.
- Sub-module axis_skid_stage (DWIDTH param; in/out valid/ready/data; occupancy contribution 0..2), instantiated STAGES times in a generate loop.
- The top holds only the adder, the chain wiring and the occupancy adder.

Test Plan:
1. Reset then stream, STAGES=2, INCR=1, ready_i=1: drive 8'h00..8'h09 back-to-back. Expect 8'h01..8'h0A on valid_o, first output 2 cycles after the first input, no gaps, occupancy_o steady at 2.
2. Wrap/saturate: data_i=8'hFF with INCR=1. Expect data_o=8'h00 without the macro, 8'hFF with AXIS_SKID_PIPE_SAT_EN.
3. Back-pressure fill: ready_i=0, valid_i=1 continuous with 8'h10, 8'h11, ….
   - ready_o falls after exactly 4 accepted beats; occupancy_o=4.
   - Release ready_i: outputs 8'h11..8'h14 in order, no loss, no duplication.
4. Random ready_i/valid_i (50% each, 10k beats): scoreboard the in-order +INCR check, and assert the valid_o/data_o stability rule under stall.
5. Async reset mid-burst: assert areset_i between clock edges with occupancy_o=3.
   - valid_o=0, occupancy_o=0, ready_o=1 before the next edge.
   - The first post-reset beat 8'h20 emerges as 8'h21.
6. STAGES=1, DWIDTH=16, INCR=16'h0100, alternating ready_i: data_i=16'hFF00 -> 16'h0000 (wrap). Latency 1; maximum occupancy_o=2.
